vpe_stream: RTL and testbench

Pipelined, handshaked vector-processing element for the accelerator datapath. Processes one `TILE`-element signed fixed-point vector beat per cycle in three modes: element-wise multiply, scalar-times-vector-plus-vector (AXPY), and dot product accumulated across multi-beat packets. It replaces the free-running, unflow-controlled tile stage with a parametrised, stallable pipeline that owns its own accumulator state.

---
 rtl/vpe_pkg.sv | 10 +
 rtl/vpe_stream_if.sv | 24 ++
 rtl/vpe_lane.sv | 41 ++++
 rtl/vpe_stream.sv | 93 +++++++++
 tb/tb_vpe_stream.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vpe_pkg.sv
// vpe_pkg: shared mode/state enums and a width-parametrised saturation helper for vpe_stream.
package vpe_pkg;
  typedef enum logic [1:0] {VMUL, AXPY, DOT, RSVD} vpe_mode_e;
  typedef enum logic {IDLE, ACCUM} acc_state_e;
  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return x > hi ? hi : x < ~hi ? ~hi : x;
  endfunction
endpackage

// File: rtl/vpe_stream_if.sv
// vpe_stream_if: input-beat and result-beat handshake bundle for vpe_stream.
interface vpe_stream_if import vpe_pkg::*; #(parameter int TILE = 8, parameter int DATA_W = 16);
  logic                     in_valid;
  logic                     in_ready;
  vpe_mode_e                in_mode;
  logic                     in_last;
  logic [TILE*DATA_W-1:0]   in_a;
  logic [TILE*DATA_W-1:0]   in_b;
  logic [DATA_W-1:0]        in_s;
  logic                     out_valid;
  logic                     out_ready;
  logic [TILE*DATA_W-1:0]   out_vec;
  logic [DATA_W-1:0]        out_scal;
  logic                     out_is_scal;
  logic                     out_sat;
  modport slave (
    input  in_valid, in_mode, in_last, in_a, in_b, in_s, out_ready,
    output in_ready, out_valid, out_vec, out_scal, out_is_scal, out_sat
  );
  modport master (
    output in_valid, in_mode, in_last, in_a, in_b, in_s, out_ready,
    input  in_ready, out_valid, out_vec, out_scal, out_is_scal, out_sat
  );
endinterface

// File: rtl/vpe_lane.sv
// vpe_lane: one element's product register (S1) and its rescale, AXPY add and saturate (S2 logic).
module vpe_lane import vpe_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv_i,
  input  logic                       axpy_i,
  input  logic                       axpy_q_i,
  input  logic signed [DATA_W-1:0]   a_i,
  input  logic signed [DATA_W-1:0]   b_i,
  input  logic signed [DATA_W-1:0]   s_i,
  output logic signed [2*DATA_W-1:0] prod_o,
  output logic [DATA_W-1:0]          res_o,
  output logic                       sat_o
);
  localparam int PW = 2 * DATA_W;
  logic signed [PW-1:0] prod_q, shifted, addend, sum;
  logic signed [DATA_W-1:0] b_q;
  logic signed [63:0] full, clamp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod_q <= '0;
      b_q    <= '0;
    end else if (adv_i) begin
      prod_q <= PW'(a_i) * PW'(axpy_i ? s_i : b_i);
      b_q    <= b_i;
    end
  // Signed temporaries keep >>> arithmetic; the sum is wide enough that it never wraps.
  always_comb begin
    shifted = prod_q >>> FRAC;
    addend  = axpy_q_i ? PW'(b_q) : PW'(0);
    sum     = shifted + addend;
    full    = 64'(sum);
    clamp   = sat_fn(full, DATA_W);
  end
  assign prod_o = prod_q;
  assign res_o  = clamp[DATA_W-1:0];
  assign sat_o  = clamp != full;
endmodule

// File: rtl/vpe_stream.sv
// vpe_stream: three-stage stallable vector PE (VMUL / AXPY / packet DOT) with a global-stall handshake.
module vpe_stream import vpe_pkg::*; #(
  parameter int TILE   = 8,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic          clk,
  input  logic          rst,
  vpe_stream_if.slave   vpe_io
);
  logic adv;
  logic v1_q, dot1_q, axpy1_q, last1_q;
  logic v2_q, dot2_q, last2_q, vsat2_q;
  logic [TILE*DATA_W-1:0] vec2_q;
  logic signed [ACC_W-1:0] sum2_q, sum_d, acc_q, base, acc_d;
  acc_state_e state_q;
  logic sticky_q, sticky_d, wrap, emit;
  logic signed [63:0] scal_full, scal_c;
  logic out_valid_q, out_is_scal_q, out_sat_q;
  logic [TILE*DATA_W-1:0] out_vec_q;
  logic [DATA_W-1:0] out_scal_q;
  logic signed [2*DATA_W-1:0] prod [TILE];
  logic [TILE-1:0][DATA_W-1:0] res;
  logic [TILE-1:0] lsat;
  assign adv = !out_valid_q || vpe_io.out_ready;
  for (genvar i = 0; i < TILE; i++) begin : g_lane
    vpe_lane #(.DATA_W(DATA_W), .FRAC(FRAC)) u_lane (
      .clk(clk), .rst(rst), .adv_i(adv),
      .axpy_i(vpe_io.in_mode == AXPY), .axpy_q_i(axpy1_q),
      .a_i(vpe_io.in_a[i*DATA_W +: DATA_W]), .b_i(vpe_io.in_b[i*DATA_W +: DATA_W]), .s_i(vpe_io.in_s),
      .prod_o(prod[i]), .res_o(res[i]), .sat_o(lsat[i])
    );
  end
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TILE; k++) sum_d = sum_d + ACC_W'(prod[k]);
  end
  // Accumulator restarts from zero whenever a packet begins in IDLE; wrap is a sign overflow of the add.
  always_comb begin
    base      = state_q == ACCUM ? acc_q : ACC_W'(0);
    acc_d     = base + sum2_q;
    wrap      = (base[ACC_W-1] == sum2_q[ACC_W-1]) && (acc_d[ACC_W-1] != base[ACC_W-1]);
    sticky_d  = (state_q == ACCUM && sticky_q) || wrap;
    scal_full = 64'(acc_d >>> FRAC);
    scal_c    = sat_fn(scal_full, DATA_W);
    emit      = v2_q && (!dot2_q || last2_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1_q, dot1_q, axpy1_q, last1_q} <= '0;
      {v2_q, dot2_q, last2_q, vsat2_q} <= '0;
      vec2_q        <= '0;
      sum2_q        <= '0;
      acc_q         <= '0;
      sticky_q      <= 1'b0;
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_vec_q     <= '0;
      out_scal_q    <= '0;
      out_is_scal_q <= 1'b0;
      out_sat_q     <= 1'b0;
    end else if (adv) begin
      v1_q        <= vpe_io.in_valid;
      dot1_q      <= vpe_io.in_mode == DOT;
      axpy1_q     <= vpe_io.in_mode == AXPY;
      last1_q     <= vpe_io.in_last;
      v2_q        <= v1_q;
      dot2_q      <= dot1_q;
      last2_q     <= last1_q;
      vec2_q      <= res;
      vsat2_q     <= |lsat;
      sum2_q      <= sum_d;
      out_valid_q <= emit;
      if (v2_q && dot2_q) begin
        state_q  <= last2_q ? IDLE : ACCUM;
        acc_q    <= last2_q ? ACC_W'(0) : acc_d;
        sticky_q <= !last2_q && sticky_d;
      end
      if (emit) begin
        out_vec_q     <= dot2_q ? '0 : vec2_q;
        out_scal_q    <= dot2_q ? scal_c[DATA_W-1:0] : '0;
        out_is_scal_q <= dot2_q;
        out_sat_q     <= dot2_q ? (sticky_d || scal_c != scal_full) : vsat2_q;
      end
    end
  assign vpe_io.in_ready    = adv;
  assign vpe_io.out_valid   = out_valid_q;
  assign vpe_io.out_vec     = out_vec_q;
  assign vpe_io.out_scal    = out_scal_q;
  assign vpe_io.out_is_scal = out_is_scal_q;
  assign vpe_io.out_sat     = out_sat_q;
endmodule

// File: tb/tb_vpe_stream.sv
// tb_vpe_stream: directed and randomized checks of vpe_stream against an integer-arithmetic model.
module tb_vpe_stream;
  import vpe_pkg::*;
  typedef struct {
    logic [127:0] vec;
    logic [15:0]  scal;
    bit           is_scal;
    bit           sat;
    bit           has_lit;
    logic [127:0] lvec;
    logic [15:0]  lscal;
    bit           lis;
    bit           lsat;
  } exp_t;
  logic clk, rst;
  vpe_stream_if #(.TILE(8), .DATA_W(16)) bus ();
  vpe_stream dut (.clk(clk), .rst(rst), .vpe_io(bus));
  int n_cmp = 0, n_fail = 0;
  exp_t q[$];
  longint acc = 0;
  bit sticky = 0;
  bit lit_en = 0, lit_is, lit_sat, rand_rdy = 0, held = 0;
  logic [15:0] lit_elem, lit_scal;
  logic [145:0] prev;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  function automatic longint clamp16(input longint x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
  endfunction
  task automatic model(input logic [1:0] m, input bit l, input logic [127:0] a, input logic [127:0] b, input logic [15:0] s);
    exp_t e;
    longint p, v, c, sum, lim;
    logic [39:0] t;
    bit emit;
    e = '{default: 0};
    emit = 1;
    lim = 64'sd1 <<< 39;
    if (m == 2) begin
      sum = 0;
      for (int i = 0; i < 8; i++)
        sum += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
      acc += sum;
      if (acc >= lim || acc < -lim) begin
        sticky = 1;
        t = acc[39:0];
        acc = longint'($signed(t));
      end
      if (l) begin
        v = acc >>> 8;
        c = clamp16(v);
        e.scal = c[15:0];
        e.is_scal = 1;
        e.sat = sticky || c != v;
        acc = 0;
        sticky = 0;
      end else emit = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        p = longint'($signed(a[i*16 +: 16])) * (m == 1 ? longint'($signed(s)) : longint'($signed(b[i*16 +: 16])));
        v = (p >>> 8) + (m == 1 ? longint'($signed(b[i*16 +: 16])) : 0);
        c = clamp16(v);
        e.vec[i*16 +: 16] = c[15:0];
        if (c != v) e.sat = 1;
      end
    end
    if (emit) begin
      if (lit_en) begin
        e.has_lit = 1;
        e.lvec = lit_is ? 128'd0 : {8{lit_elem}};
        e.lscal = lit_scal;
        e.lis = lit_is;
        e.lsat = lit_sat;
      end
      q.push_back(e);
    end
  endtask
  // Single checker: model bookkeeping, handshake rule, output hold and result comparison.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        acc = 0;
        sticky = 0;
        held = 0;
      end else begin
        chk("in_ready_rule", 160'(bus.in_ready), 160'(!bus.out_valid || bus.out_ready));
        if (bus.in_valid && bus.in_ready) model(bus.in_mode, bus.in_last, bus.in_a, bus.in_b, bus.in_s);
        if (bus.out_valid) begin
          if (held) chk("hold_stable", 160'({bus.out_vec, bus.out_scal, bus.out_is_scal, bus.out_sat}), 160'(prev));
          if (bus.out_ready) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_output: got vec %h scal %h, required no output", bus.out_vec, bus.out_scal);
            end else begin
              e = q.pop_front();
              chk("out_vec", 160'(bus.out_vec), 160'(e.vec));
              chk("out_scal", 160'(bus.out_scal), 160'(e.scal));
              chk("out_is_scal", 160'(bus.out_is_scal), 160'(e.is_scal));
              chk("out_sat", 160'(bus.out_sat), 160'(e.sat));
              if (e.has_lit) begin
                chk("lit_vec", 160'(bus.out_vec), 160'(e.lvec));
                chk("lit_scal", 160'(bus.out_scal), 160'(e.lscal));
                chk("lit_is_scal", 160'(bus.out_is_scal), 160'(e.lis));
                chk("lit_sat", 160'(bus.out_sat), 160'(e.lsat));
                chk("model_vs_lit", 160'({e.vec, e.scal, e.sat}), 160'({e.lvec, e.lscal, e.lsat}));
              end
            end
          end
        end
        held = bus.out_valid && !bus.out_ready;
        prev = {bus.out_vec, bus.out_scal, bus.out_is_scal, bus.out_sat};
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = $urandom_range(0, 3) != 0;
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [1:0] m, input bit l, input logic [127:0] a, input logic [127:0] b, input logic [15:0] s);
    int n = 0;
    bus.in_mode = vpe_mode_e'(m);
    bus.in_last = l;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_s = s;
    bus.in_valid = 1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no acceptance, required in_ready within 50 cycles");
    end
    sync();
    bus.in_valid = 0;
  endtask
  task automatic lbeat(input logic [1:0] m, input bit l, input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                       input logic [15:0] el, input logic [15:0] sc, input bit is, input bit st);
    lit_elem = el;
    lit_scal = sc;
    lit_is = is;
    lit_sat = st;
    lit_en = 1;
    beat(m, l, {8{a}}, {8{b}}, s);
    lit_en = 0;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 160'(q.size()), 160'(0));
    sync();
  endtask
  function automatic logic [127:0] rvec();
    logic [127:0] v;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      v[i*16 +: 16] = r[31] ? r[15:0] : 16'($signed(r[9:0]));
    end
    return v;
  endfunction
  initial begin
    int n;
    logic [31:0] rs;
    rst = 1;
    bus.in_valid = 0;
    bus.in_mode = VMUL;
    bus.in_last = 0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_s = '0;
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", 160'(bus.in_ready), 160'(1));
    chk("rst_out_valid", 160'(bus.out_valid), 160'(0));
    chk("rst_out_vec", 160'(bus.out_vec), 160'(0));
    chk("rst_out_scal", 160'(bus.out_scal), 160'(0));
    chk("rst_flags", 160'({bus.out_is_scal, bus.out_sat}), 160'(0));
    sync();
    lbeat(0, 0, 16'h0200, 16'h0180, 16'h0000, 16'h0300, 16'h0000, 0, 0);
    wait_out(n);
    chk("vmul_latency", 160'(n), 160'(3));
    sync();
    lbeat(0, 0, 16'h7F00, 16'h7F00, 16'h0000, 16'h7FFF, 16'h0000, 0, 1);
    lbeat(0, 0, 16'h8000, 16'h7F00, 16'h0000, 16'h8000, 16'h0000, 0, 1);
    lbeat(1, 0, 16'h0100, 16'h0080, 16'hFF00, 16'hFF80, 16'h0000, 0, 0);
    drain();
    beat(2, 0, {8{16'h0100}}, {8{16'h0100}}, 16'h0);
    lbeat(2, 1, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h1000, 1, 0);
    drain();
    bus.out_ready = 0;
    beat(2, 0, {8{16'h0100}}, {8{16'h0100}}, 16'h0);
    lbeat(0, 0, 16'h0200, 16'h0180, 16'h0000, 16'h0300, 16'h0000, 0, 0);
    lbeat(2, 1, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h1000, 1, 0);
    wait_out(n);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", 160'(bus.in_ready), 160'(0));
      chk("stall_vec", 160'(bus.out_vec), 160'({8{16'h0300}}));
      if (k < 4) @(negedge clk);
    end
    sync();
    bus.out_ready = 1;
    drain();
    beat(2, 0, {8{16'h0100}}, {8{16'h0100}}, 16'h0);
    rst = 1;
    sync();
    rst = 0;
    @(negedge clk);
    chk("rst2_in_ready", 160'(bus.in_ready), 160'(1));
    chk("rst2_out_valid", 160'(bus.out_valid), 160'(0));
    sync();
    lbeat(2, 1, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0800, 1, 0);
    drain();
    rand_rdy = 1;
    for (int k = 0; k < 400; k++) begin
      rs = $urandom;
      beat(rs[1:0], rs[3:2] == 0, rvec(), rvec(), rs[4] ? rs[31:16] : 16'($signed(rs[15:6])));
      if (rs[7:5] == 0) sync();
    end
    rand_rdy = 0;
    sync();
    bus.out_ready = 1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
